// File: rtl/fifo_stream_pkg.sv
// Shared types and helpers for the FIFO read-side stream engine.
package fifo_stream_pkg;

    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        CHK_RUN  = 2'd0,
        CHK_PASS = 2'd1,
        CHK_FAIL = 2'd2
    } chk_state_t;

    // Width of an occupancy counter that must reach 'depth' inclusive.
    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_stream_skid.sv
// Register-array FIFO used as the output skid buffer; flush empties it in one cycle.
module fifo_stream_skid
    import fifo_stream_pkg::*;
#(
    parameter int  DATA_W = DATA_W_DEFAULT,
    parameter int  DEPTH  = 4,
    localparam int LVL_W  = level_w(DEPTH)
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [LVL_W-1:0]  level
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_wr;
    logic              do_rd;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign do_rd = rd_en && (level != '0);
    assign do_wr = wr_en && ((level != LVL_FULL) || do_rd);

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
            if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
            if (do_wr && !do_rd)
                level <= level + 1'b1;
            else if (do_rd && !do_wr)
                level <= level - 1'b1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (do_wr && !flush)
            mem[wr_ptr] <= wr_data;
    end

    // Storage is not reset, so the head is masked to zero while empty.
    assign rd_data = (level != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side engine for the vendor FIFO: pops, absorbs read latency, streams bytes via a skid buffer.
// Optional incrementing-pattern checker is built when FIFO_STREAM_CHECK_EN is defined.
//
//   state    | meaning
//   CHK_RUN  | comparing beats against the expected incrementing pattern
//   CHK_PASS | CHECK_LEN consecutive matches seen; sticky until RESET/FLUSH
//   CHK_FAIL | a mismatch was seen; sticky until RESET/FLUSH
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int                DATA_W     = DATA_W_DEFAULT,
    parameter int                RD_LAT     = 1,
    parameter int                SKID_DEPTH = 4,
    parameter logic [DATA_W-1:0] CHECK_SEED = 8'h65,
    parameter int                CHECK_LEN  = 3,
    localparam int               LVL_W      = level_w(SKID_DEPTH)
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              FIFO_EMPTY,
    input  logic [DATA_W-1:0] FIFO_Q,
    output logic              FIFO_RDEN,
    input  logic              FLUSH,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [LVL_W-1:0]  LEVEL
`ifdef FIFO_STREAM_CHECK_EN
    ,
    output logic              CHECK_PASS,
    output logic              CHECK_FAIL
`endif
);

    logic [RD_LAT-1:0] inflight;
    int unsigned       inflight_cnt;
    logic              beat;

    always_comb begin
        inflight_cnt = 0;
        for (int i = 0; i < RD_LAT; i++) begin
            if (inflight[i]) inflight_cnt++;
        end
    end

    // Counting every outstanding pop against the skid space guarantees it never overflows.
    assign FIFO_RDEN = !RESET && !FIFO_EMPTY && !FLUSH
                       && ((32'(LEVEL) + inflight_cnt) < 32'(SKID_DEPTH));

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            inflight <= '0;
        end else if (FLUSH) begin
            inflight <= '0;
        end else begin
            inflight[0] <= FIFO_RDEN;
            for (int i = 1; i < RD_LAT; i++)
                inflight[i] <= inflight[i-1];
        end
    end

    assign OUT_VALID = (LEVEL != '0);
    assign beat      = OUT_VALID && OUT_READY;

    fifo_stream_skid #(
        .DATA_W (DATA_W),
        .DEPTH  (SKID_DEPTH)
    ) u_skid (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .flush   (FLUSH),
        .wr_en   (inflight[RD_LAT-1]),
        .wr_data (FIFO_Q),
        .rd_en   (beat),
        .rd_data (OUT_DATA),
        .level   (LEVEL)
    );

`ifdef FIFO_STREAM_CHECK_EN
    localparam int CNT_W = $clog2(CHECK_LEN + 1);

    chk_state_t        chk_state;
    chk_state_t        chk_state_nx;
    logic [DATA_W-1:0] chk_exp;
    logic [DATA_W-1:0] chk_exp_nx;
    logic [CNT_W-1:0]  chk_cnt;
    logic [CNT_W-1:0]  chk_cnt_nx;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            chk_state <= CHK_RUN;
            chk_exp   <= CHECK_SEED;
            chk_cnt   <= '0;
        end else begin
            chk_state <= chk_state_nx;
            chk_exp   <= chk_exp_nx;
            chk_cnt   <= chk_cnt_nx;
        end
    end

    always_comb begin
        chk_state_nx = chk_state;
        chk_exp_nx   = chk_exp;
        chk_cnt_nx   = chk_cnt;
        if (FLUSH) begin
            chk_state_nx = CHK_RUN;
            chk_exp_nx   = CHECK_SEED;
            chk_cnt_nx   = '0;
        end else if (beat && (chk_state == CHK_RUN)) begin
            chk_exp_nx = chk_exp + 1'b1;
            if (OUT_DATA != chk_exp)
                chk_state_nx = CHK_FAIL;
            else if ((32'(chk_cnt) + 1) == CHECK_LEN)
                chk_state_nx = CHK_PASS;
            else
                chk_cnt_nx = chk_cnt + 1'b1;
        end
    end

    assign CHECK_PASS = (chk_state == CHK_PASS);
    assign CHECK_FAIL = (chk_state == CHK_FAIL);
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed scoreboard bench for fifo_stream_reader against a behavioural RD_LAT=1 vendor FIFO.
module tb_fifo_stream_reader;
    import fifo_stream_pkg::*;

    localparam int LVL_W = level_w(4);

    logic             CLOCK      = 1'b0;
    logic             RESET      = 1'b1;
    logic             FIFO_EMPTY = 1'b1;
    logic [7:0]       FIFO_Q     = 8'h00;
    logic             FLUSH      = 1'b0;
    logic             OUT_READY  = 1'b0;
    logic             FIFO_RDEN;
    logic [7:0]       OUT_DATA;
    logic             OUT_VALID;
    logic [LVL_W-1:0] LEVEL;
`ifdef FIFO_STREAM_CHECK_EN
    logic             CHECK_PASS;
    logic             CHECK_FAIL;
`endif

    logic       empty_mask = 1'b0;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         beats = 0;

    fifo_stream_reader #(
        .DATA_W     (8),
        .RD_LAT     (1),
        .SKID_DEPTH (4)
    ) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .FIFO_EMPTY (FIFO_EMPTY),
        .FIFO_Q     (FIFO_Q),
        .FIFO_RDEN  (FIFO_RDEN),
        .FLUSH      (FLUSH),
        .OUT_DATA   (OUT_DATA),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .LEVEL      (LEVEL)
`ifdef FIFO_STREAM_CHECK_EN
        ,
        .CHECK_PASS (CHECK_PASS),
        .CHECK_FAIL (CHECK_FAIL)
`endif
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic load(input logic [7:0] b, input bit expect_out);
        fifo_q.push_back(b);
        if (expect_out) exp_q.push_back(b);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < budget) begin
            @(posedge CLOCK);
            n++;
        end
        if (exp_q.size() != 0 || fifo_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: timeout with %0d bytes still expected", name, exp_q.size());
        end
        repeat (2) @(posedge CLOCK);
        #1;
    endtask

    // Vendor FIFO model: Q valid the cycle after RdEn, Empty refreshed shortly after each edge.
    always @(posedge CLOCK) begin
        if (FIFO_RDEN) begin
            check("rden_while_empty", int'(FIFO_EMPTY), 0);
            if (fifo_q.size() != 0) FIFO_Q <= fifo_q.pop_front();
        end
        #2;
        FIFO_EMPTY = empty_mask || (fifo_q.size() == 0);
    end

    // Scoreboard monitor: a beat happens at the next edge whenever valid and ready are both high.
    always @(negedge CLOCK) begin
        if (!RESET && OUT_VALID && OUT_READY) begin
            beats++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_beat: got %0h, expected no beat", OUT_DATA);
            end else begin
                check("beat_data", int'(OUT_DATA), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach the end, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int first_rden, last_rden, n_rden, first_valid, n_valid, lvl_mid, b0;
        int first_pass, first_fail, n_b, second_beat;

        // Reset held with a non-empty FIFO
        load(8'h65, 1'b1);
        load(8'h66, 1'b1);
        load(8'h67, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge CLOCK);
            check("rst_rden", int'(FIFO_RDEN), 0);
            check("rst_valid", int'(OUT_VALID), 0);
            check("rst_level", int'(LEVEL), 0);
        end
        check("rst_data", int'(OUT_DATA), 0);
        step();
        RESET     = 1'b0;
        OUT_READY = 1'b1;

        // Three-byte stream at full rate
        first_rden = -1; last_rden = -1; n_rden = 0;
        first_valid = -1; n_valid = 0; lvl_mid = -1; first_pass = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge CLOCK);
            if (FIFO_RDEN) begin
                if (first_rden < 0) first_rden = k;
                last_rden = k;
                n_rden++;
            end
            if (OUT_VALID) begin
                if (first_valid < 0) first_valid = k;
                n_valid++;
            end
            if (first_rden >= 0 && k == first_rden + 3) lvl_mid = int'(LEVEL);
`ifdef FIFO_STREAM_CHECK_EN
            if (CHECK_PASS && first_pass < 0) first_pass = k;
`endif
        end
        check("s2_first_rden", first_rden, 0);
        check("s2_rden_count", n_rden, 3);
        check("s2_last_rden", last_rden, 2);
        check("s2_first_valid", first_valid, 2);
        check("s2_valid_cycles", n_valid, 3);
        check("s2_level_streaming", lvl_mid, 1);
`ifdef FIFO_STREAM_CHECK_EN
        check("s2_pass_cycle", first_pass, 5);
        check("s2_fail_low", int'(CHECK_FAIL), 0);
`endif

        // Backpressure: ten bytes, consumer stalled
        step();
        OUT_READY = 1'b0;
        for (int i = 0; i < 10; i++) load(8'h10 + 8'(i), 1'b1);
        n_rden = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge CLOCK);
            if (FIFO_RDEN) n_rden++;
        end
        check("s3_rden_count", n_rden, 4);
        check("s3_level_full", int'(LEVEL), 4);
        check("s3_valid_held", int'(OUT_VALID), 1);
        check("s3_head_held", int'(OUT_DATA), 8'h10);
        step();
        OUT_READY = 1'b1;
        wait_drain("s3_drain", 60);
        check("s3_level_empty", int'(LEVEL), 0);

        // Empty flag toggling every cycle
        for (int i = 0; i < 6; i++) load(8'h30 + 8'(i), 1'b1);
        b0 = beats;
        for (int k = 0; k < 30; k++) begin
            step();
            empty_mask = ~empty_mask;
        end
        empty_mask = 1'b0;
        wait_drain("s4_drain", 40);
        check("s4_beats", beats - b0, 6);

        // Flush with three buffered and one in flight; fifth byte stays in the FIFO
        OUT_READY = 1'b0;
        for (int i = 0; i < 5; i++) load(8'h50 + 8'(i), (i == 4));
        b0 = beats;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLOCK);
            if (LEVEL == 3) break;
        end
        check("s5_level_before", int'(LEVEL), 3);
        check("s5_rden_capped", int'(FIFO_RDEN), 0);
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        @(negedge CLOCK);
        check("s5_level_after", int'(LEVEL), 0);
        check("s5_valid_after", int'(OUT_VALID), 0);
`ifdef FIFO_STREAM_CHECK_EN
        check("s5_pass_cleared", int'(CHECK_PASS), 0);
`endif
        step();
        OUT_READY = 1'b1;
        wait_drain("s5_drain", 30);
        check("s5_beats", beats - b0, 1);
        check("s5_level_settled", int'(LEVEL), 0);

        // Pattern break: 65 then 68
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
`ifdef FIFO_STREAM_CHECK_EN
        @(negedge CLOCK);
        check("s6_fail_cleared", int'(CHECK_FAIL), 0);
        step();
`endif
        load(8'h65, 1'b1);
        load(8'h68, 1'b1);
        load(8'h69, 1'b1);
        load(8'h6a, 1'b1);
        n_b = 0; second_beat = -1; first_fail = -1;
        for (int k = 0; k < 14; k++) begin
            @(negedge CLOCK);
`ifdef FIFO_STREAM_CHECK_EN
            if (CHECK_FAIL && first_fail < 0) first_fail = k;
`endif
            if (OUT_VALID && OUT_READY) begin
                n_b++;
                if (n_b == 2) second_beat = k;
            end
        end
        check("s6_beats", n_b, 4);
        wait_drain("s6_drain", 20);
`ifdef FIFO_STREAM_CHECK_EN
        check("s6_fail_cycle", first_fail, second_beat + 1);
        check("s6_fail_sticky", int'(CHECK_FAIL), 1);
        check("s6_pass_low", int'(CHECK_PASS), 0);
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        @(negedge CLOCK);
        check("s6_fail_flushed", int'(CHECK_FAIL), 0);
`endif

        repeat (3) @(posedge CLOCK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
